// File: rtl/sync_multi.sv
// sync_multi -- multi-bit asynchronous input synchroniser with per-bit
// edge detection and an optional per-bit stability filter.
//
// Build option: define SYNC_MULTI_FILTER_EN to add the stability filter.
// With the filter, sync_out only takes a new raw value after that value has
// been stable for FILT_CNT consecutive cycles. Without it, sync_out is the
// last synchroniser stage and FILT_CNT is ignored.
//
// Parameters:
//   WIDTH    number of independent input bits
//   STAGES   synchroniser depth (>= 2)
//   RST_VAL  reset value of stage flops, sync_out and edge history
//   FILT_CNT stable cycles required before sync_out updates (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       synchronous active-low reset
//   async_in    [WIDTH] asynchronous inputs
//   sync_out    [WIDTH] synchronised (optionally filtered) level
//   rise        [WIDTH] one-cycle pulse on 0->1 of sync_out
//   fall        [WIDTH] one-cycle pulse on 1->0 of sync_out
//   any_change  OR of all rise/fall bits
module sync_multi #(
    parameter int unsigned      WIDTH    = 1,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned      FILT_CNT = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // Elaboration-time guard against illegal configurations.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_multi: STAGES must be 2 or more");
        end
        if (FILT_CNT < 1) begin : g_bad_filt
            $error("sync_multi: FILT_CNT must be 1 or more");
        end
    endgenerate

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_hist;

    // Synchroniser chain; reset discards any in-flight samples.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_stage[k] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= async_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign w_raw = r_stage[STAGES-1];

`ifdef SYNC_MULTI_FILTER_EN
    localparam int unsigned   CW       = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_sync;

    // Per-bit filter: count consecutive cycles where raw disagrees with the
    // output; any agreement clears the count, so glitches never accumulate.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sync <= RST_VAL;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (w_raw[i] == r_sync[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_sync[i] <= w_raw[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_sync = r_sync;
`else
    assign w_sync = w_raw;
`endif

    // Edge history; resetting it alongside sync_out prevents a spurious
    // pulse on the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_hist <= RST_VAL;
        end else begin
            r_hist <= w_sync;
        end
    end

    assign sync_out   = w_sync;
    assign rise       = w_sync & ~r_hist;
    assign fall       = ~w_sync & r_hist;
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_sync_multi.sv
// tb_sync_multi -- directed self-checking bench for sync_multi.
// Main DUT: WIDTH=4, STAGES=2, FILT_CNT=4, RST_VAL=0.
// Depth DUT: WIDTH=4, STAGES=3.
// Expected latencies follow the SYNC_MULTI_FILTER_EN build option.
module tb_sync_multi;

`ifdef SYNC_MULTI_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 6;   // STAGES + FILT_CNT
    localparam int LAT3 = 7;   // 3 + FILT_CNT
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 2;   // STAGES
    localparam int LAT3 = 3;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] async_in;
    logic [3:0] sync_out, rise, fall;
    logic       any_change;
    logic [3:0] async_in3;
    logic [3:0] sync3, rise3, fall3;
    logic       any3;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_s, exp_r, exp_f, prev_s;
    logic       exp_a;

    sync_multi #(.WIDTH(4), .STAGES(2), .RST_VAL(4'h0), .FILT_CNT(4)) u_dut (
        .clk(clk), .n_rst(n_rst), .async_in(async_in),
        .sync_out(sync_out), .rise(rise), .fall(fall), .any_change(any_change)
    );

    sync_multi #(.WIDTH(4), .STAGES(3), .RST_VAL(4'h0), .FILT_CNT(4)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .async_in(async_in3),
        .sync_out(sync3), .rise(rise3), .fall(fall3), .any_change(any3)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        n_rst     = 1'b0;
        async_in  = 4'h0;
        async_in3 = 4'h0;
        tick();
        tick();
        n_rst = 1'b1;
        repeat (LAT3 + 3) tick();
    endtask

    task automatic test_reset;
        n_rst     = 1'b0;
        async_in  = 4'hF;
        async_in3 = 4'h0;
        tick();
        tick();
        n_cmp++;
        if (sync_out !== 4'h0) begin
            n_err++;
            $display("FAIL reset_sync: got %h expected %h", sync_out, 4'h0);
        end
        n_cmp++;
        if ({rise, fall, any_change} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_edges: got %h expected %h", {rise, fall, any_change}, 9'h0);
        end
        n_rst  = 1'b1;
        prev_s = 4'h0;
        for (int n = 1; n <= LAT + 2; n++) begin
            tick();
            exp_s = (n >= LAT) ? 4'hF : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL release_sync n=%0d: got %h expected %h", n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL release_edges n=%0d: got %h expected %h", n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
        // Reset without a clock edge must change nothing.
        n_rst = 1'b0;
        #2;
        n_cmp++;
        if (sync_out !== 4'hF) begin
            n_err++;
            $display("FAIL reset_no_edge: got %h expected %h", sync_out, 4'hF);
        end
        tick();
        n_cmp++;
        if (sync_out !== 4'h0) begin
            n_err++;
            $display("FAIL reset_edge_sync: got %h expected %h", sync_out, 4'h0);
        end
        n_cmp++;
        if ({rise, fall, any_change} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_edge_pulses: got %h expected %h", {rise, fall, any_change}, 9'h0);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_step;
        do_reset();
        prev_s = 4'h0;
        for (int n = 1; n <= LAT + 2; n++) begin
            async_in = 4'h5;
            tick();
            exp_s = (n >= LAT) ? 4'h5 : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL step_sync n=%0d: got %h expected %h", n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL step_edges n=%0d: got %h expected %h", n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    // Bit0 pulse of len cycles; len=3 is a glitch to the filter, len=4 passes.
    task automatic test_glitch(input int len);
        do_reset();
        prev_s = 4'h0;
        for (int n = 1; n <= LAT + 6; n++) begin
            async_in = (n <= len) ? 4'h1 : 4'h0;
            tick();
            if (FILT && len < 4)
                exp_s = 4'h0;
            else
                exp_s = (n >= LAT && n <= LAT + len - 1) ? 4'h1 : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL glitch%0d_sync n=%0d: got %h expected %h", len, n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL glitch%0d_edges n=%0d: got %h expected %h", len, n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    task automatic test_mixed;
        do_reset();
        async_in = 4'h5;
        repeat (LAT + 2) tick();
        prev_s = 4'h5;
        for (int n = 1; n <= LAT + 2; n++) begin
            async_in = 4'hA;
            tick();
            exp_s = (n >= LAT) ? 4'hA : 4'h5;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL mixed_sync n=%0d: got %h expected %h", n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL mixed_edges n=%0d: got %h expected %h", n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    task automatic test_reset_mid_filter;
        do_reset();
        async_in = 4'h1;
        repeat (4) tick();
        exp_s = FILT ? 4'h0 : 4'h1;
        n_cmp++;
        if (sync_out !== exp_s) begin
            n_err++;
            $display("FAIL midrst_pre: got %h expected %h", sync_out, exp_s);
        end
        n_rst = 1'b0;
        tick();
        n_cmp++;
        if ({sync_out, rise, fall, any_change} !== 13'h0) begin
            n_err++;
            $display("FAIL midrst_in_reset: got %h expected %h",
                     {sync_out, rise, fall, any_change}, 13'h0);
        end
        n_rst  = 1'b1;
        prev_s = 4'h0;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            exp_s = (n >= LAT) ? 4'h1 : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL midrst_sync n=%0d: got %h expected %h", n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL midrst_edges n=%0d: got %h expected %h", n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    // Bit1 toggles every cycle for six cycles.
    task automatic test_back_to_back;
        do_reset();
        prev_s = 4'h0;
        for (int n = 1; n <= LAT + 8; n++) begin
            async_in = (n <= 6 && (n % 2) == 1) ? 4'h2 : 4'h0;
            tick();
            if (FILT)
                exp_s = 4'h0;
            else
                exp_s = (n >= LAT && n <= LAT + 5 && ((n - LAT) % 2) == 0) ? 4'h2 : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync_out !== exp_s) begin
                n_err++;
                $display("FAIL b2b_sync n=%0d: got %h expected %h", n, sync_out, exp_s);
            end
            n_cmp++;
            if ({rise, fall, any_change} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL b2b_edges n=%0d: got %h expected %h", n,
                         {rise, fall, any_change}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    task automatic test_depth;
        do_reset();
        prev_s = 4'h0;
        for (int n = 1; n <= LAT3 + 2; n++) begin
            async_in3 = 4'h8;
            tick();
            exp_s = (n >= LAT3) ? 4'h8 : 4'h0;
            exp_r = exp_s & ~prev_s;
            exp_f = ~exp_s & prev_s;
            exp_a = |(exp_r | exp_f);
            prev_s = exp_s;
            n_cmp++;
            if (sync3 !== exp_s) begin
                n_err++;
                $display("FAIL depth_sync n=%0d: got %h expected %h", n, sync3, exp_s);
            end
            n_cmp++;
            if ({rise3, fall3, any3} !== {exp_r, exp_f, exp_a}) begin
                n_err++;
                $display("FAIL depth_edges n=%0d: got %h expected %h", n,
                         {rise3, fall3, any3}, {exp_r, exp_f, exp_a});
            end
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        async_in  = 4'hF;
        async_in3 = 4'h0;
        test_reset();
        test_step();
        test_glitch(3);
        test_glitch(4);
        test_mixed();
        test_reset_mid_filter();
        test_back_to_back();
        test_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_multi.md
Name: sync_multi

Overview:
- Parametrised multi-bit input synchroniser with a configurable flop-chain depth, per-bit edge detection and an optional per-bit glitch filter.
- Sits at every asynchronous input boundary (buttons, external strobes, cross-domain status bits) and feeds clean, single-cycle edge events to downstream FSMs and counters.
- Replaces hand-instantiated two-flop synchronisers.

Parameters:
- WIDTH, 1: number of independent input bits.
- STAGES, 2: synchroniser flop depth; legal values are 2 and above.
- RST_VAL, {WIDTH{1'b0}}: reset value of all stage flops, sync_out and the edge-history register.
- FILT_CNT, 4: consecutive stable cycles required before sync_out updates; legal values are 1 and above. Used only when the filter is compiled in.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- n_rst  input  1  reset, synchronous and active-low.
- async_in  input  WIDTH  asynchronous inputs; no timing relationship to clk.
- sync_out  output  WIDTH  synchronised (and, if enabled, filtered) level.
- rise  output  WIDTH  one-cycle pulse per bit on a 0->1 change of sync_out.
- fall  output  WIDTH  one-cycle pulse per bit on a 1->0 change of sync_out.
- any_change  output  1  OR-reduction of (rise | fall).

Behaviour:
- Reset is synchronous. At a clk rising edge with n_rst=0:
  - all STAGES flops load RST_VAL;
  - the history register loads RST_VAL;
  - filter counters load 0;
  - so sync_out=RST_VAL and rise=fall=0, any_change=0 from the next cycle.
- n_rst=0 with no clk edge changes nothing.
- Stage chain: stage[0] <= async_in and stage[k] <= stage[k-1] each edge. raw = stage[STAGES-1].
- No combinational path from async_in to any output.
- Edge detect:
  - hist <= sync_out each edge.
  - rise = sync_out & ~hist; fall = ~sync_out & hist.
  - Pulses are combinational from registered state and last exactly one cycle, which is the first cycle sync_out shows the new value.
  - Because hist resets to RST_VAL, no spurious pulse occurs after reset.
- Filter compiled out: sync_out = raw. Latency from an async_in change, sampled at edge 1, to sync_out is STAGES edges.
- Filter compiled in: sync_out is a register per bit, with a counter cnt[i] of width $clog2(FILT_CNT+1). Each edge, one of three cases applies:
  - raw[i] == sync_out[i]: cnt[i] <= 0.
  - raw[i] != sync_out[i] and cnt[i] < FILT_CNT-1: cnt[i] <= cnt[i]+1.
  - raw[i] != sync_out[i] and cnt[i] == FILT_CNT-1: sync_out[i] <= raw[i] and cnt[i] <= 0.
- Filter consequences:
  - Latency is STAGES+FILT_CNT edges.
  - A raw pulse shorter than FILT_CNT cycles produces no change and no edge pulse.
  - Any return of raw to match sync_out clears the count; no accumulation across glitches.
- Bits are fully independent.
  - Simultaneous changes on several bits give simultaneous pulses; any_change is a single cycle.
  - A rise on one bit and a fall on another in the same cycle are both reported.
- Reset mid-filter: counters clear, so after release a change needs the full FILT_CNT stable cycles.
- Reset mid-chain: in-flight samples are discarded.
- Back-to-back changes: sync_out may toggle on consecutive cycles without the filter. Each toggle gives its own one-cycle pulse, and rise and fall are never high together on one bit.

Optional Feature:
- Macro: SYNC_MULTI_FILTER_EN.
- Defined: the per-bit stability filter and counters are instantiated as above; FILT_CNT is used.
- Undefined: no counters; sync_out = raw; FILT_CNT is ignored; latency is STAGES.
- Ports and edge-detect behaviour are identical in both builds.

Test Plan:
All scenarios use WIDTH=4, STAGES=2, FILT_CNT=4 and RST_VAL=4'h0 unless stated.
1. Reset: async_in=4'hF.
   - Before any edge with n_rst=0: no change.
   - Hold n_rst=0 for 2 edges: sync_out=4'h0 and rise=fall=0, any_change=0.
   - Release: with the filter, sync_out=4'hF 6 edges later; without it, 2 edges later.
2. Step: after reset with async_in=0, drive async_in=4'h5.
   - sync_out=4'h5 exactly 6 edges later with the filter, or 2 edges later without it.
   - rise=4'h5 and any_change=1 for exactly 1 cycle; fall=0.
3. Glitch: bit0 high for 3 cycles, then low.
   - With the filter: sync_out stays 4'h0 and no pulses.
   - Without the filter: rise=4'h1 for 1 cycle, then fall=4'h1 3 cycles later.
   - Repeat with 4 cycles high: with the filter, sync_out[0] rises.
4. Mixed edges: from sync_out=4'h5, drive async_in=4'hA.
   - Same cycle: rise=4'hA, fall=4'h5, any_change=1 for 1 cycle only.
5. Reset mid-filter: raw mismatch held for 2 cycles (cnt=2), then n_rst=0 for 1 edge, then release with the mismatch still present.
   - sync_out updates only after a further STAGES+4 edges.
6. Depth variant: STAGES=3, filter compiled out.
   - Step 0->1 on bit3 gives sync_out[3]=1 after exactly 3 edges, with one rise pulse.
